// File: rtl/q2_pkg.sv
// Shared constants and state encoding for the memory responder.
// Default geometry matches the 12-bit X/P address path and 4-bit dbus.
package q2_pkg;

    localparam int AW_DEF   = 12;
    localparam int DW_DEF   = 4;
    localparam int WAIT_DEF = 2;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_LATCH = 3'd1;
    localparam state_t S_WAITS = 3'd2;
    localparam state_t S_DRIVE = 3'd3;
    localparam state_t S_WRITE = 3'd4;
    localparam state_t S_DONE  = 3'd5;

endpackage

// File: rtl/mem_array.sv
// Word storage: synchronous write, combinational read, never reset.
// Contents are undefined until written.
module mem_array #(
    parameter int AW = 12,
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          wr_en_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [2**AW];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_responder.sv
// Bus-cycle responder: latches an active-low address, then serves a read
// (with WAIT wait states) or a write, pulsing ack once per request.
//
//   state | meaning
//   IDLE  | waiting for req; address and direction captured on exit
//   LATCH | direction known; write data captured here for writes
//   WAITS | read wait states, down-counter runs to 0
//   DRIVE | read data on dbus_out, dbus_oe and ack high
//   WRITE | captured word stored, ack high
//   DONE  | waiting for req to drop so a held req cannot retrigger
module mem_responder
    import q2_pkg::*;
#(
    parameter int AW   = AW_DEF,
    parameter int DW   = DW_DEF,
    parameter int WAIT = WAIT_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] abus_n,
    input  logic          req,
    input  logic          we,
    input  logic [DW-1:0] dbus_in,
    output logic [DW-1:0] dbus_out,
    output logic          dbus_oe,
    output logic          ack,
    output logic          busy
);

    localparam bit         HAS_WAIT  = (WAIT > 0);
    localparam logic [3:0] WAIT_LOAD = HAS_WAIT ? 4'(WAIT - 1) : 4'd0;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q,  addr_d;
    logic          we_q,    we_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [3:0]    cnt_q,   cnt_d;
    logic [DW-1:0] rdata;
    logic          mem_wr;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    addr_d  = ~abus_n;
                    we_d    = we;
                    state_d = S_LATCH;
                end
            end
            S_LATCH: begin
                if (we_q) begin
                    wdata_d = dbus_in;
                    state_d = S_WRITE;
                end else if (HAS_WAIT) begin
                    cnt_d   = WAIT_LOAD;
                    state_d = S_WAITS;
                end else begin
                    state_d = S_DRIVE;
                end
            end
            S_WAITS: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_DRIVE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DRIVE, S_WRITE: state_d = S_DONE;
            S_DONE: begin
                if (!req) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
        end
    end

    // Write enable decodes straight from state, so an async reset in WRITE
    // removes it before the next edge and memory is left untouched.
    assign mem_wr = (state_q == S_WRITE);

    mem_array #(
        .AW (AW),
        .DW (DW)
    ) u_mem_array (
        .clk     (clk),
        .wr_en_i (mem_wr),
        .addr_i  (addr_q),
        .wdata_i (wdata_q),
        .rdata_o (rdata)
    );

    assign dbus_oe  = (state_q == S_DRIVE);
    assign dbus_out = dbus_oe ? rdata : '0;
    assign ack      = (state_q == S_DRIVE) || (state_q == S_WRITE);
    assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Randomized scoreboard bench for mem_responder (WAIT=2) plus a small
// directed check of a WAIT=0 instance.
module tb_mem_responder;

    localparam int TB_WAIT = 2;
    localparam int RD_LAT  = TB_WAIT + 2;
    localparam int WR_LAT  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] abus_n;
    logic        req, we;
    logic [3:0]  dbus_in, dbus_out;
    logic        dbus_oe, ack, busy;

    logic [11:0] abus0_n;
    logic        req0, we0;
    logic [3:0]  dbus_in0, dbus_out0;
    logic        dbus_oe0, ack0, busy0;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit mon_en = 1'b0;

    typedef struct {
        bit         rd;
        bit         known;
        logic [3:0] data;
        int         due;
    } exp_t;

    exp_t       sb_q [$];
    logic [3:0] model_mem [int];

    mem_responder #(.AW(12), .DW(4), .WAIT(TB_WAIT)) dut (
        .clk      (clk),
        .rst      (rst),
        .abus_n   (abus_n),
        .req      (req),
        .we       (we),
        .dbus_in  (dbus_in),
        .dbus_out (dbus_out),
        .dbus_oe  (dbus_oe),
        .ack      (ack),
        .busy     (busy)
    );

    mem_responder #(.AW(12), .DW(4), .WAIT(0)) dut0 (
        .clk      (clk),
        .rst      (rst),
        .abus_n   (abus0_n),
        .req      (req0),
        .we       (we0),
        .dbus_in  (dbus_in0),
        .dbus_out (dbus_out0),
        .dbus_oe  (dbus_oe0),
        .ack      (ack0),
        .busy     (busy0)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // Monitor: every ack must match the oldest outstanding request.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (ack) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_ack", int'(ack), 0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("ack_cycle", cyc, e.due);
                    chk("ack_oe", int'(dbus_oe), int'(e.rd));
                    if (!e.rd) chk("wr_dbus_out", int'(dbus_out), 0);
                    else if (e.known) chk("rd_data", int'(dbus_out), int'(e.data));
                end
            end else begin
                chk("idle_bus", int'({dbus_oe, dbus_out}), 0);
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy) chk("idle_timeout", int'(busy), 0);
    endtask

    task automatic issue(input bit w, input logic [11:0] a, input logic [3:0] d,
                         input int hold);
        exp_t e;
        wait_idle();
        abus_n  = ~a;
        we      = w;
        dbus_in = d;
        req     = 1'b1;
        e.rd    = !w;
        e.due   = cyc + (w ? WR_LAT : RD_LAT);
        e.known = w || model_mem.exists(int'(a));
        e.data  = (!w && e.known) ? model_mem[int'(a)] : 4'h0;
        sb_q.push_back(e);
        if (w) model_mem[int'(a)] = d;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            abus_n = 12'($urandom);
            if (i >= 1) dbus_in = 4'($urandom);
        end
        if (hold > (w ? WR_LAT : RD_LAT)) chk("busy_held", int'(busy), 1);
        req = 1'b0;
        we  = 1'($urandom);
    endtask

    initial begin
        int         lat;
        logic [3:0] d0;
        logic       oe0;
        rst = 1'b1; req = 1'b0; we = 1'b0; abus_n = '1; dbus_in = '0;
        req0 = 1'b0; we0 = 1'b0; abus0_n = '1; dbus_in0 = '0;
        #2;
        chk("rst_ack", int'(ack), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_oe", int'(dbus_oe), 0);
        chk("rst_out", int'(dbus_out), 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        mon_en = 1'b1;

        // Write 0x5 at 0x123, read it back.
        issue(1'b1, 12'h123, 4'h5, WR_LAT);
        issue(1'b0, 12'h123, 4'h0, RD_LAT);

        // WAIT=0 instance: write then read address 0xFFF.
        abus0_n = 12'h000; we0 = 1'b1; dbus_in0 = 4'h7; req0 = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("w0_ack", int'(ack0), 1);
        req0 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("w0_idle", int'(busy0), 0);
        we0 = 1'b0; req0 = 1'b1; lat = -1; d0 = 4'h0; oe0 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ack0 && lat < 0) begin
                lat = i; d0 = dbus_out0; oe0 = dbus_oe0;
            end
        end
        @(posedge clk); #1 req0 = 1'b0;
        chk("w0_rd_latency", lat, 2);
        chk("w0_rd_data", int'(d0), 7);
        chk("w0_rd_oe", int'(oe0), 1);

        // Held req: one ack only, busy until req falls.
        issue(1'b1, 12'h200, 4'h3, 12);
        @(posedge clk); #1;
        chk("held_to_idle", int'(busy), 0);
        issue(1'b0, 12'h200, 4'h0, RD_LAT);

        // Early withdrawal still commits.
        issue(1'b1, 12'h010, 4'hA, 1);
        issue(1'b0, 12'h010, 4'h0, RD_LAT);

        // Reset while in WRITE leaves memory unmodified.
        wait_idle();
        abus_n = ~12'h010; we = 1'b1; dbus_in = 4'h6; req = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1; req = 1'b0;
        #1;
        chk("rstw_ack", int'(ack), 0);
        chk("rstw_busy", int'(busy), 0);
        @(posedge clk); #1 rst = 1'b0;
        issue(1'b0, 12'h010, 4'h0, RD_LAT);

        // Reset in WAITS with req held; cycle restarts on first edge after.
        wait_idle();
        abus_n = ~12'h123; we = 1'b0; req = 1'b1;
        @(posedge clk); #1 abus_n = 12'($urandom);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("rstr_busy", int'(busy), 0);
        chk("rstr_ack", int'(ack), 0);
        chk("rstr_oe", int'(dbus_oe), 0);
        chk("rstr_out", int'(dbus_out), 0);
        @(posedge clk); #1;
        abus_n = ~12'h123;
        rst = 1'b0;
        begin
            exp_t e;
            e.rd = 1'b1; e.known = 1'b1; e.data = 4'h5; e.due = cyc + RD_LAT;
            sb_q.push_back(e);
        end
        for (int i = 0; i < RD_LAT; i++) begin
            @(posedge clk); #1 abus_n = 12'($urandom);
        end
        req = 1'b0;

        // Random traffic over a small hot set plus the full address space.
        for (int n = 0; n < 80; n++) begin
            bit          w;
            logic [11:0] a;
            int          h, base;
            w    = 1'($urandom);
            a    = ($urandom_range(0, 2) != 0) ? 12'($urandom_range(0, 7)) : 12'($urandom);
            base = w ? WR_LAT : RD_LAT;
            case ($urandom_range(0, 3))
                0:       h = 1;
                1:       h = base + int'($urandom_range(1, 4));
                default: h = base;
            endcase
            issue(w, a, 4'($urandom), h);
        end

        repeat (10) @(posedge clk);
        #1;
        chk("sb_drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
